// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and a radix-2 multi-cycle multiplier.
// A multiply stalls the pipe for BITS+1 cycles and delivers its result in the DONE cycle.
module ex_stage #(
    parameter int BITS       = 32,
    parameter int REG_WORDS  = 32,
    parameter int OP_BITS    = 4,
    parameter int SHIFT_BITS = 5
) (
    input  logic                             clk,
    input  logic                             rst_,
    input  logic [BITS-1:0]                  r1_data_s3,
    input  logic [BITS-1:0]                  r2_data_s3,
    input  logic [$clog2(REG_WORDS)-1:0]     r1_addr_s3,
    input  logic [$clog2(REG_WORDS)-1:0]     r2_addr_s3,
    input  logic [BITS-1:0]                  sign_ext_imm_s3,
    input  logic                             alu_imm_s3,
    input  logic [SHIFT_BITS-1:0]            shamt_s3,
    input  logic [OP_BITS-1:0]               alu_op_s3,
    input  logic                             halt_s3,
    input  logic [$clog2(REG_WORDS)-1:0]     waddr_s4,
    input  logic                             rw_s4,
    input  logic [BITS-1:0]                  alu_out_s4,
    input  logic [$clog2(REG_WORDS)-1:0]     waddr_s5,
    input  logic                             rw_s5,
    input  logic [BITS-1:0]                  wdata_s5,
    output logic [BITS-1:0]                  alu_out,
    output logic                             stall
);
    localparam int ADDR_LEFT = $clog2(REG_WORDS) - 1;
    localparam logic [5:0] CNT_LAST = 6'(BITS - 1);

    localparam logic [OP_BITS-1:0] OP_ADD   = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_SUB   = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_AND   = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_OR    = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] OP_XOR   = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] OP_NOR   = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] OP_SLL   = OP_BITS'(6);
    localparam logic [OP_BITS-1:0] OP_SRL   = OP_BITS'(7);
    localparam logic [OP_BITS-1:0] OP_SRA   = OP_BITS'(8);
    localparam logic [OP_BITS-1:0] OP_SLT   = OP_BITS'(9);
    localparam logic [OP_BITS-1:0] OP_SLTU  = OP_BITS'(10);
    localparam logic [OP_BITS-1:0] OP_LUI   = OP_BITS'(11);
    localparam logic [OP_BITS-1:0] OP_MUL   = OP_BITS'(12);
    localparam logic [OP_BITS-1:0] OP_MULHU = OP_BITS'(13);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_nxt;
    logic [5:0]          cnt;
    logic [2*BITS-1:0]   prod;
    logic [BITS-1:0]     a_lat, b_lat;
    logic                hi_lat;
    logic [BITS-1:0]     fwd_a, fwd_b, op_a, op_b, res;
    logic [BITS:0]       step_sum;
    logic                mul_start;

    // Register 0 is hardwired, so it is never a forwarding target; EX/MEM wins over WB.
    assign fwd_a = (r1_addr_s3 != '0 && !rw_s4 && waddr_s4 == r1_addr_s3) ? alu_out_s4 :
                   (r1_addr_s3 != '0 && !rw_s5 && waddr_s5 == r1_addr_s3) ? wdata_s5 :
                   r1_data_s3;
    assign fwd_b = (r2_addr_s3 != '0 && !rw_s4 && waddr_s4 == r2_addr_s3) ? alu_out_s4 :
                   (r2_addr_s3 != '0 && !rw_s5 && waddr_s5 == r2_addr_s3) ? wdata_s5 :
                   r2_data_s3;
    assign op_a = fwd_a;
    assign op_b = alu_imm_s3 ? sign_ext_imm_s3 : fwd_b;

    always_comb begin
        res = '0;
        case (alu_op_s3)
            OP_ADD:  res = op_a + op_b;
            OP_SUB:  res = op_a - op_b;
            OP_AND:  res = op_a & op_b;
            OP_OR:   res = op_a | op_b;
            OP_XOR:  res = op_a ^ op_b;
            OP_NOR:  res = ~(op_a | op_b);
            OP_SLL:  res = op_b << shamt_s3;
            OP_SRL:  res = op_b >> shamt_s3;
            OP_SRA:  res = $signed(op_b) >>> shamt_s3;
            OP_SLT:  res = BITS'($signed(op_a) < $signed(op_b));
            OP_SLTU: res = BITS'(op_a < op_b);
            OP_LUI:  res = op_b << 16;
            default: res = '0;
        endcase
    end

    assign mul_start = (state == IDLE) && !halt_s3 &&
                       (alu_op_s3 == OP_MUL || alu_op_s3 == OP_MULHU);

    // Shift-right multiplier: add A into the upper half when the current B bit is set.
    assign step_sum = {1'b0, prod[2*BITS-1:BITS]} + (b_lat[0] ? {1'b0, a_lat} : '0);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        alu_out   = res;
        case (state)
            IDLE: if (mul_start) begin
                stall     = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                alu_out   = hi_lat ? prod[2*BITS-1:BITS] : prod[BITS-1:0];
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state  <= IDLE;
            cnt    <= '0;
            prod   <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            hi_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mul_start) begin
                a_lat  <= op_a;
                b_lat  <= op_b;
                hi_lat <= (alu_op_s3 == OP_MULHU);
                prod   <= '0;
                cnt    <= '0;
            end else if (state == BUSY) begin
                prod  <= {step_sum, prod[BITS-1:1]};
                b_lat <= b_lat >> 1;
                cnt   <= cnt + 6'd1;
            end
        end
    end
endmodule
